// File: rtl/riscv_types.sv
// Shared machine-width definitions for the integer datapath blocks.
package riscv_types;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] xlen_t;

endpackage : riscv_types

// File: rtl/div_radix2_step.sv
// One restoring-division iteration: conditional subtract of the aligned divisor
// and shift of the next quotient bit into the partial quotient.
module div_radix2_step
    import riscv_types::*;
(
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] shifted_i,
    input  logic [XLEN-1:0] q_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] q_o
);

    // The single subtractor; its borrow-out doubles as the rem < shifted compare.
    logic [XLEN:0] diff;
    logic          ge;

    assign diff  = {1'b0, rem_i} - {1'b0, shifted_i};
    assign ge    = ~diff[XLEN];
    assign rem_o = ge ? diff[XLEN-1:0] : rem_i;
    assign q_o   = {q_i[XLEN-2:0], ge};

endmodule : div_radix2_step

// File: rtl/div_sequencer.sv
// Iterative unsigned 32-bit divider with CLZ-based early-out, divide-by-zero
// shortcut, result reuse and flush; one operation in flight at a time.
module div_sequencer
    import riscv_types::*;
#(
    parameter int ID_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] unsigned_dividend,
    input  logic [XLEN-1:0] unsigned_divisor,
    input  logic [4:0]      dividend_clz,
    input  logic [4:0]      divisor_clz,
    input  logic            divisor_is_zero,
    input  logic            reuse_result,
    input  logic [ID_W-1:0] in_id,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder,
    output logic [ID_W-1:0] out_id,
    output logic [1:0]      dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_seq_state_t;

    div_seq_state_t  state_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] shifted_q;
    logic [5:0]      count_q;
    logic [ID_W-1:0] id_q;
    logic [XLEN-1:0] last_quo_q;
    logic [XLEN-1:0] last_rem_q;

    logic [XLEN-1:0] rem_d;
    logic [XLEN-1:0] quo_d;
    logic [4:0]      shamt;

    // Handshakes: a request transfers on a clk edge with in_valid && in_ready;
    // a result transfers on a clk edge with out_valid && out_ready. Both
    // sides hold their payload stable while valid is high and ready is low.
    assign in_ready  = (state_q == IDLE) && !flush && !rst;
    assign out_valid = (state_q == DONE);
    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign out_id    = id_q;
    assign dbg_state = state_q;
    assign shamt     = divisor_clz - dividend_clz;

    div_radix2_step u_step (
        .rem_i     (rem_q),
        .shifted_i (shifted_q),
        .q_i       (quo_q),
        .rem_o     (rem_d),
        .q_o       (quo_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            quo_q      <= '0;
            shifted_q  <= '0;
            count_q    <= '0;
            id_q       <= '0;
            last_quo_q <= '0;
            last_rem_q <= '0;
        end else if (flush) begin
            // Abort without committing; last-result registers keep their value.
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        id_q <= in_id;
                        if (divisor_is_zero) begin
                            quo_q   <= '1;
                            rem_q   <= unsigned_dividend;
                            state_q <= DONE;
                        end else if (reuse_result) begin
                            quo_q   <= last_quo_q;
                            rem_q   <= last_rem_q;
                            state_q <= DONE;
                        end else if (dividend_clz > divisor_clz) begin
                            quo_q   <= '0;
                            rem_q   <= unsigned_dividend;
                            state_q <= DONE;
                        end else begin
                            quo_q     <= '0;
                            rem_q     <= unsigned_dividend;
                            shifted_q <= unsigned_divisor << shamt;
                            count_q   <= {1'b0, shamt} + 6'd1;
                            state_q   <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    rem_q     <= rem_d;
                    quo_q     <= quo_d;
                    shifted_q <= shifted_q >> 1;
                    count_q   <= count_q - 6'd1;
                    if (count_q == 6'd1) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        last_quo_q <= quo_q;
                        last_rem_q <= rem_q;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule : div_sequencer

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: hand-computed quotients, latencies and
// flush/reset behaviour, checked with immediate assertions.
module tb_div_sequencer;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] unsigned_dividend;
    logic [31:0] unsigned_divisor;
    logic [4:0]  dividend_clz;
    logic [4:0]  divisor_clz;
    logic        divisor_is_zero;
    logic        reuse_result;
    logic [3:0]  in_id;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic [3:0]  out_id;
    logic [1:0]  dbg_state;

    int errors = 0;
    int checks = 0;
    int lat;

    div_sequencer #(.ID_W(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .flush             (flush),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .unsigned_dividend (unsigned_dividend),
        .unsigned_divisor  (unsigned_divisor),
        .dividend_clz      (dividend_clz),
        .divisor_clz       (divisor_clz),
        .divisor_is_zero   (divisor_is_zero),
        .reuse_result      (reuse_result),
        .in_id             (in_id),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .quotient          (quotient),
        .remainder         (remainder),
        .out_id            (out_id),
        .dbg_state         (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request from IDLE and return the cycles until out_valid (bounded).
    task automatic do_op(input logic [31:0] dvd, input logic [31:0] dvs,
                         input logic [4:0] dclz, input logic [4:0] vclz,
                         input logic dz, input logic reuse, input logic [3:0] id,
                         output int cycles);
        unsigned_dividend = dvd;
        unsigned_divisor  = dvs;
        dividend_clz      = dclz;
        divisor_clz       = vclz;
        divisor_is_zero   = dz;
        reuse_result      = reuse;
        in_id             = id;
        in_valid          = 1'b1;
        step();
        in_valid = 1'b0;
        cycles   = 1;
        while (!out_valid && cycles < 100) begin
            step();
            cycles++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        unsigned_dividend = '0; unsigned_divisor = '0;
        dividend_clz = '0; divisor_clz = '0;
        divisor_is_zero = 1'b0; reuse_result = 1'b0; in_id = '0;

        step();
        step();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        check("post_rst_quotient", quotient, 32'd0);
        check("post_rst_remainder", remainder, 32'd0);
        check("post_rst_out_id", 32'(out_id), 32'd0);

        // Divide by zero shortcut.
        do_op(32'h1234, 32'h0, 5'd19, 5'd31, 1'b1, 1'b0, 4'd1, lat);
        check("dz_latency", 32'(lat), 32'd1);
        check("dz_quotient", quotient, 32'hFFFF_FFFF);
        check("dz_remainder", remainder, 32'h1234);
        check("dz_out_id", 32'(out_id), 32'd1);
        consume();
        check("dz_consumed", 32'(out_valid), 32'd0);

        // Dividend smaller than divisor by CLZ compare.
        do_op(32'd5, 32'd9, 5'd29, 5'd28, 1'b0, 1'b0, 4'd2, lat);
        check("early_latency", 32'(lat), 32'd1);
        check("early_quotient", quotient, 32'd0);
        check("early_remainder", remainder, 32'd5);
        consume();

        // Full 32-iteration divide.
        do_op(32'hFFFF_FFFF, 32'd1, 5'd0, 5'd31, 1'b0, 1'b0, 4'd3, lat);
        check("max_latency", 32'(lat), 32'd33);
        check("max_quotient", quotient, 32'hFFFF_FFFF);
        check("max_remainder", remainder, 32'd0);
        consume();

        do_op(32'd1000, 32'd10, 5'd22, 5'd28, 1'b0, 1'b0, 4'd4, lat);
        check("k_latency", 32'(lat), 32'd8);
        check("k_quotient", quotient, 32'd100);
        check("k_remainder", remainder, 32'd0);
        consume();

        // 100/7 with a 3-cycle stall on the result side.
        do_op(32'd100, 32'd7, 5'd25, 5'd29, 1'b0, 1'b0, 4'd5, lat);
        check("s_latency", 32'(lat), 32'd6);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_quotient", quotient, 32'd14);
            check("stall_remainder", remainder, 32'd2);
            check("stall_out_id", 32'(out_id), 32'd5);
            check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        consume();
        check("s_consumed_in_ready", 32'(in_ready), 32'd1);

        // Reuse takes priority over the CLZ early-out.
        do_op(32'd3, 32'd9, 5'd30, 5'd28, 1'b0, 1'b1, 4'd6, lat);
        check("reuse_latency", 32'(lat), 32'd1);
        check("reuse_quotient", quotient, 32'd14);
        check("reuse_remainder", remainder, 32'd2);
        consume();

        // Flush on the third BUSY cycle of a long divide.
        unsigned_dividend = 32'hFFFF_FFFF; unsigned_divisor = 32'd1;
        dividend_clz = 5'd0; divisor_clz = 5'd31;
        divisor_is_zero = 1'b0; reuse_result = 1'b0; in_id = 4'd7;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        flush = 1'b1;
        #1;
        check("flush_in_ready_low", 32'(in_ready), 32'd0);
        step();
        flush = 1'b0;
        #1;
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        do_op(32'd0, 32'd1, 5'd31, 5'd31, 1'b0, 1'b1, 4'd8, lat);
        check("flush_reuse_quotient", quotient, 32'd14);
        check("flush_reuse_remainder", remainder, 32'd2);
        consume();

        // Flush with in_valid in IDLE must not accept.
        flush = 1'b1; in_valid = 1'b1; divisor_is_zero = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0; divisor_is_zero = 1'b0;
        step();
        check("idle_flush_no_accept", 32'(out_valid), 32'd0);

        // Flush and out_ready together in DONE: nothing committed.
        do_op(32'd5, 32'd9, 5'd29, 5'd28, 1'b0, 1'b0, 4'd9, lat);
        check("fd_quotient", quotient, 32'd0);
        flush = 1'b1; out_ready = 1'b1;
        step();
        flush = 1'b0; out_ready = 1'b0;
        check("fd_out_valid", 32'(out_valid), 32'd0);
        do_op(32'd0, 32'd1, 5'd31, 5'd31, 1'b0, 1'b1, 4'd10, lat);
        check("fd_reuse_quotient", quotient, 32'd14);
        check("fd_reuse_remainder", remainder, 32'd2);
        consume();

        // Reset in the middle of BUSY.
        unsigned_dividend = 32'd100; unsigned_divisor = 32'd7;
        dividend_clz = 5'd25; divisor_clz = 5'd29; in_id = 4'd11;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        check("rb_out_valid", 32'(out_valid), 32'd0);
        check("rb_quotient", quotient, 32'd0);
        check("rb_remainder", remainder, 32'd0);
        check("rb_out_id", 32'(out_id), 32'd0);
        rst = 1'b0;
        step();
        do_op(32'd55, 32'd3, 5'd26, 5'd30, 1'b0, 1'b1, 4'd12, lat);
        check("rb_reuse_latency", 32'(lat), 32'd1);
        check("rb_reuse_quotient", quotient, 32'd0);
        check("rb_reuse_remainder", remainder, 32'd0);
        consume();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_div_sequencer
